model_state_feedback_controller: RTL and testbench

MODEL_STATE_FEEDBACK_CONTROLLER -- requirements
Module: model_state_feedback_controller

---
 rtl/model_state_pkg.sv | 18 +
 rtl/model_state_feedback_mac.sv | 30 +++
 rtl/model_state_feedback_controller.sv | 180 ++++++++++++++++++
 tb/tb_model_state_feedback_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_state_pkg.sv
// Shared definitions for the state-feedback controller: FSM encoding and
// the element-select codes that appear on REQ_SEL_OUT.
package model_state_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_A = 3'd1,
        S_WAIT_A  = 3'd2,
        S_ISSUE_B = 3'd3,
        S_WAIT_B  = 3'd4,
        S_WRITE   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/model_state_feedback_mac.sv
// Multiply-accumulate with synchronous clear; the accumulator keeps only the
// low DATA_SIZE bits, so it wraps in two's complement.
module model_state_feedback_mac #(
    parameter int DATA_SIZE = 64
) (
    input  logic                        CLK,
    input  logic                        i_clear,
    input  logic                        i_enable,
    input  logic signed [DATA_SIZE-1:0] i_op_a,
    input  logic signed [DATA_SIZE-1:0] i_op_b,
    output logic signed [DATA_SIZE-1:0] o_acc
);

    logic signed [DATA_SIZE-1:0] r_acc_p0;
    logic signed [DATA_SIZE-1:0] w_prod;

    assign w_prod = i_op_a * i_op_b;

    // clear has priority so a new row never inherits a late product
    always_ff @(posedge CLK) begin
        if (i_clear) begin
            r_acc_p0 <= '0;
        end else if (i_enable) begin
            r_acc_p0 <= r_acc_p0 + w_prod;
        end
    end

    assign o_acc = r_acc_p0;

endmodule

// File: rtl/model_state_feedback_controller.sv
// Computes x_next = A*x + B*u one row at a time, fetching each matrix/vector
// element pair through a single-outstanding request/response port.
module model_state_feedback_controller
    import model_state_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_M_IN,
    output logic                    REQ_VALID,
    input  logic                    REQ_READY,
    output logic                    REQ_SEL_OUT,
    output logic [CONTROL_SIZE-1:0] REQ_I_OUT,
    output logic [CONTROL_SIZE-1:0] REQ_J_OUT,
    input  logic                    RSP_VALID,
    input  logic [DATA_SIZE-1:0]    RSP_MATRIX_IN,
    input  logic [DATA_SIZE-1:0]    RSP_VECTOR_IN,
    output logic                    DATA_OUT_VALID,
    output logic [CONTROL_SIZE-1:0] DATA_I_OUT,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DONE
);

    state_t                  r_state;
    state_t                  w_next;
    logic [CONTROL_SIZE-1:0] r_n;
    logic [CONTROL_SIZE-1:0] r_m;
    logic [CONTROL_SIZE-1:0] r_i;
    logic [CONTROL_SIZE-1:0] r_j;
    logic [CONTROL_SIZE-1:0] r_data_i;
    logic [DATA_SIZE-1:0]    r_data;

    logic                    w_accept;
    logic                    w_rsp_take;
    logic                    w_mac_clear;
    logic [CONTROL_SIZE:0]   w_j_inc;
    logic [CONTROL_SIZE:0]   w_i_inc;
    logic                    w_last_a;
    logic                    w_last_b;
    logic                    w_last_row;
    logic signed [DATA_SIZE-1:0] w_acc;

    assign w_accept   = (r_state == S_IDLE) && START;
    assign w_rsp_take = RSP_VALID && ((r_state == S_WAIT_A) || (r_state == S_WAIT_B));

    // one extra bit so index+1 never wraps before comparing with the size
    assign w_j_inc    = {1'b0, r_j} + {{CONTROL_SIZE{1'b0}}, 1'b1};
    assign w_i_inc    = {1'b0, r_i} + {{CONTROL_SIZE{1'b0}}, 1'b1};
    assign w_last_a   = w_j_inc >= {1'b0, r_n};
    assign w_last_b   = w_j_inc >= {1'b0, r_m};
    assign w_last_row = w_i_inc >= {1'b0, r_n};

    assign w_mac_clear = !RST || w_accept || (r_state == S_WRITE);

    model_state_feedback_mac #(
        .DATA_SIZE (DATA_SIZE)
    ) u_mac (
        .CLK      (CLK),
        .i_clear  (w_mac_clear),
        .i_enable (RST && w_rsp_take),
        .i_op_a   (RSP_MATRIX_IN),
        .i_op_b   (RSP_VECTOR_IN),
        .o_acc    (w_acc)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_m      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_data   <= '0;
            r_data_i <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_n <= SIZE_N_IN;
                        r_m <= SIZE_M_IN;
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                S_WAIT_A: begin
                    if (RSP_VALID) begin
                        r_j <= w_last_a ? '0 : w_j_inc[CONTROL_SIZE-1:0];
                    end
                end
                S_WAIT_B: begin
                    if (RSP_VALID && !w_last_b) begin
                        r_j <= w_j_inc[CONTROL_SIZE-1:0];
                    end
                end
                S_WRITE: begin
                    r_data   <= w_acc;
                    r_data_i <= r_i;
                    r_j      <= '0;
                    if (!w_last_row) begin
                        r_i <= w_i_inc[CONTROL_SIZE-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        READY          = 1'b0;
        REQ_VALID      = 1'b0;
        REQ_SEL_OUT    = SEL_A;
        REQ_I_OUT      = '0;
        REQ_J_OUT      = '0;
        DATA_OUT_VALID = 1'b0;
        DATA_I_OUT     = r_data_i;
        DATA_OUT       = r_data;
        DONE           = 1'b0;
        case (r_state)
            S_IDLE: begin
                READY = 1'b1;
                if (START) begin
                    w_next = (SIZE_N_IN != '0) ? S_ISSUE_A : S_FINISH;
                end
            end
            S_ISSUE_A: begin
                REQ_VALID   = 1'b1;
                REQ_SEL_OUT = SEL_A;
                REQ_I_OUT   = r_i;
                REQ_J_OUT   = r_j;
                if (REQ_READY) begin
                    w_next = S_WAIT_A;
                end
            end
            S_WAIT_A: begin
                if (RSP_VALID) begin
                    if (!w_last_a) begin
                        w_next = S_ISSUE_A;
                    end else begin
                        w_next = (r_m != '0) ? S_ISSUE_B : S_WRITE;
                    end
                end
            end
            S_ISSUE_B: begin
                REQ_VALID   = 1'b1;
                REQ_SEL_OUT = SEL_B;
                REQ_I_OUT   = r_i;
                REQ_J_OUT   = r_j;
                if (REQ_READY) begin
                    w_next = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (RSP_VALID) begin
                    w_next = w_last_b ? S_WRITE : S_ISSUE_B;
                end
            end
            S_WRITE: begin
                DATA_OUT_VALID = 1'b1;
                DATA_I_OUT     = r_i;
                DATA_OUT       = w_acc;
                w_next         = w_last_row ? S_FINISH : S_ISSUE_A;
            end
            S_FINISH: begin
                DONE   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_model_state_feedback_controller.sv
// Randomized bench: a memory-backed responder serves element requests and a
// plain-arithmetic matrix model predicts every row of x_next.
module tb_model_state_feedback_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic [3:0]  SIZE_N_IN;
    logic [3:0]  SIZE_M_IN;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_SEL_OUT;
    logic [3:0]  REQ_I_OUT;
    logic [3:0]  REQ_J_OUT;
    logic        RSP_VALID;
    logic [63:0] RSP_MATRIX_IN;
    logic [63:0] RSP_VECTOR_IN;
    logic        DATA_OUT_VALID;
    logic [3:0]  DATA_I_OUT;
    logic [63:0] DATA_OUT;
    logic        DONE;

    model_state_feedback_controller #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .READY          (READY),
        .SIZE_N_IN      (SIZE_N_IN),
        .SIZE_M_IN      (SIZE_M_IN),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_SEL_OUT    (REQ_SEL_OUT),
        .REQ_I_OUT      (REQ_I_OUT),
        .REQ_J_OUT      (REQ_J_OUT),
        .RSP_VALID      (RSP_VALID),
        .RSP_MATRIX_IN  (RSP_MATRIX_IN),
        .RSP_VECTOR_IN  (RSP_VECTOR_IN),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .DATA_I_OUT     (DATA_I_OUT),
        .DATA_OUT       (DATA_OUT),
        .DONE           (DONE)
    );

    always #5 CLK = ~CLK;

    logic [63:0] A [16][16];
    logic [63:0] B [16][16];
    logic [63:0] X [16];
    logic [63:0] U [16];

    int n_tests = 0;
    int n_fail  = 0;

    int stall_max  = 0;
    int delay_max  = 0;
    bit fixed_mode = 1'b1;
    bit hang_b     = 1'b0;
    bit waiting_b  = 1'b0;
    int hs_cnt     = 0;
    int hs_b_cnt   = 0;
    int done_cnt   = 0;
    bit rst_seen   = 1'b0;

    logic [63:0] out_d [$];
    logic [3:0]  out_i [$];
    logic [63:0] last_d;
    logic [3:0]  last_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] model_row(int i, int n, int m);
        logic [63:0] acc;
        acc = 64'd0;
        for (int j = 0; j < n; j++) acc = acc + A[i][j] * X[j];
        for (int j = 0; j < m; j++) acc = acc + B[i][j] * U[j];
        return acc;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    always @(posedge CLK) rst_seen = RST;

    // output monitor: collects written rows, checks held values, counts DONE
    always @(negedge CLK) begin
        if (!rst_seen) begin
            last_d = 64'd0;
            last_i = 4'd0;
        end else begin
            if (DATA_OUT_VALID) begin
                out_d.push_back(DATA_OUT);
                out_i.push_back(DATA_I_OUT);
                last_d = DATA_OUT;
                last_i = DATA_I_OUT;
            end else begin
                chk("hold_data", DATA_OUT, last_d);
                chk("hold_idx", {60'd0, DATA_I_OUT}, {60'd0, last_i});
            end
            if (DONE) done_cnt++;
        end
    end

    // element responder backed by A/B/X/U
    initial begin
        logic       c_sel;
        logic [3:0] c_i;
        logic [3:0] c_j;
        int         st;
        int         dl;
        REQ_READY     = 1'b0;
        RSP_VALID     = 1'b0;
        RSP_MATRIX_IN = 64'd0;
        RSP_VECTOR_IN = 64'd0;
        forever begin
            @(negedge CLK);
            if (REQ_VALID !== 1'b1) continue;
            c_sel = REQ_SEL_OUT;
            c_i   = REQ_I_OUT;
            c_j   = REQ_J_OUT;
            st = fixed_mode ? stall_max : int'($urandom_range(0, stall_max));
            for (int k = 0; k < st; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    RSP_VALID     = 1'b1;
                    RSP_MATRIX_IN = rnd64();
                    RSP_VECTOR_IN = rnd64();
                end
                @(negedge CLK);
                RSP_VALID = 1'b0;
                chk("stall_reqv", {63'd0, REQ_VALID}, 64'd1);
                chk("stall_sel", {63'd0, REQ_SEL_OUT}, {63'd0, c_sel});
                chk("stall_i", {60'd0, REQ_I_OUT}, {60'd0, c_i});
                chk("stall_j", {60'd0, REQ_J_OUT}, {60'd0, c_j});
            end
            REQ_READY = 1'b1;
            @(negedge CLK);
            REQ_READY = 1'b0;
            hs_cnt++;
            if (c_sel) hs_b_cnt++;
            if (hang_b && c_sel) begin
                waiting_b = 1'b1;
                while (hang_b) @(negedge CLK);
                waiting_b = 1'b0;
                continue;
            end
            dl = fixed_mode ? delay_max : int'($urandom_range(0, delay_max));
            for (int k = 0; k < dl; k++) begin
                chk("wait_reqv", {63'd0, REQ_VALID}, 64'd0);
                @(negedge CLK);
            end
            chk("wait_reqv", {63'd0, REQ_VALID}, 64'd0);
            RSP_VALID     = 1'b1;
            RSP_MATRIX_IN = c_sel ? B[c_i][c_j] : A[c_i][c_j];
            RSP_VECTOR_IN = c_sel ? U[c_j] : X[c_j];
            @(negedge CLK);
            RSP_VALID     = 1'b0;
            RSP_MATRIX_IN = rnd64();
            RSP_VECTOR_IN = rnd64();
        end
    end

    task automatic start_run(input int n, input int m);
        out_d.delete();
        out_i.delete();
        SIZE_N_IN = 4'(n);
        SIZE_M_IN = 4'(m);
        START     = 1'b1;
        tick();
        START     = 1'b0;
        SIZE_N_IN = 4'($urandom);
        SIZE_M_IN = 4'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int c0;
        int k;
        c0 = done_cnt;
        k  = 0;
        while (done_cnt == c0 && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != c0), 64'd1);
        repeat (3) tick();
        chk({tag, "_done_once"}, 64'(done_cnt - c0), 64'd1);
        chk({tag, "_ready"}, {63'd0, READY}, 64'd1);
    endtask

    task automatic check_rows(input string tag, input int n, input int m);
        chk({tag, "_rows"}, 64'(out_d.size()), 64'(n));
        for (int i = 0; i < n && i < out_d.size(); i++) begin
            chk({tag, "_data"}, out_d[i], model_row(i, n, m));
            chk({tag, "_idx"}, {60'd0, out_i[i]}, 64'(i));
        end
    endtask

    task automatic run_case(input string tag, input int n, input int m);
        start_run(n, m);
        wait_done(tag);
        check_rows(tag, n, m);
    endtask

    task automatic load_basic;
        A[0][0] = 64'd1; A[0][1] = 64'd2; A[1][0] = 64'd3; A[1][1] = 64'd4;
        X[0] = 64'd5; X[1] = 64'd6;
        B[0][0] = 64'd1; B[1][0] = 64'd2;
        U[0] = 64'd7;
    endtask

    initial begin
        int k;
        int hs0;
        int n;
        int m;
        RST       = 1'b0;
        START     = 1'b0;
        SIZE_N_IN = 4'd0;
        SIZE_M_IN = 4'd0;
        repeat (3) tick();
        chk("rst_ready", {63'd0, READY}, 64'd1);
        chk("rst_reqv", {63'd0, REQ_VALID}, 64'd0);
        chk("rst_dov", {63'd0, DATA_OUT_VALID}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_data", DATA_OUT, 64'd0);
        chk("rst_idx", {60'd0, DATA_I_OUT}, 64'd0);
        RST = 1'b1;
        tick();

        // basic 2x2 + 2x1 case with an immediate responder
        load_basic();
        run_case("basic", 2, 1);
        if (out_d.size() == 2) begin
            chk("basic_row0", out_d[0], 64'd24);
            chk("basic_row1", out_d[1], 64'd53);
        end

        // same data, stalled acceptance and delayed responses
        stall_max = 3;
        delay_max = 2;
        run_case("stalled", 2, 1);
        if (out_d.size() == 2) begin
            chk("stalled_row0", out_d[0], 64'd24);
            chk("stalled_row1", out_d[1], 64'd53);
        end
        stall_max = 0;
        delay_max = 0;

        // identity A, no B columns
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) A[i][j] = (i == j) ? 64'd1 : 64'd0;
        X[0] = 64'd9; X[1] = 64'd8; X[2] = 64'd7;
        hs0 = hs_b_cnt;
        run_case("ident", 3, 0);
        chk("ident_no_b", 64'(hs_b_cnt - hs0), 64'd0);

        // empty state vector: straight to DONE
        hs0 = hs_cnt;
        out_d.delete();
        out_i.delete();
        SIZE_N_IN = 4'd0;
        SIZE_M_IN = 4'd3;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("n0_done", {63'd0, DONE}, 64'd1);
        chk("n0_busy", {63'd0, READY}, 64'd0);
        tick();
        chk("n0_done_end", {63'd0, DONE}, 64'd0);
        chk("n0_ready", {63'd0, READY}, 64'd1);
        repeat (3) tick();
        chk("n0_no_req", 64'(hs_cnt - hs0), 64'd0);
        chk("n0_no_out", 64'(out_d.size()), 64'd0);

        // reset while waiting on the first B element
        A[0][0] = 64'd10; X[0] = 64'd10; B[0][0] = 64'd10; U[0] = 64'd10;
        hang_b = 1'b1;
        start_run(1, 1);
        k = 0;
        while (!waiting_b && k < 500) begin
            tick();
            k++;
        end
        chk("abort_reach_waitb", {63'd0, waiting_b}, 64'd1);
        RST = 1'b0;
        tick();
        tick();
        chk("abort_ready", {63'd0, READY}, 64'd1);
        chk("abort_reqv", {63'd0, REQ_VALID}, 64'd0);
        chk("abort_dov", {63'd0, DATA_OUT_VALID}, 64'd0);
        chk("abort_data", DATA_OUT, 64'd0);
        A[0][0] = 64'd2; X[0] = 64'd3; B[0][0] = 64'd4; U[0] = 64'd5;
        out_d.delete();
        out_i.delete();
        RST = 1'b1;
        hang_b = 1'b0;
        SIZE_N_IN = 4'd1;
        SIZE_M_IN = 4'd1;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done("restart");
        check_rows("restart", 1, 1);
        if (out_d.size() == 1) chk("restart_val", out_d[0], 64'd26);

        // wrapping product; extra START pulses while busy are ignored
        A[0][0] = 64'h8000_0000_0000_0000;
        X[0] = 64'd2;
        out_d.delete();
        out_i.delete();
        SIZE_N_IN = 4'd1;
        SIZE_M_IN = 4'd0;
        START = 1'b1;
        tick();
        SIZE_N_IN = 4'd3;
        SIZE_M_IN = 4'd2;
        tick();
        tick();
        START = 1'b0;
        wait_done("wrap");
        check_rows("wrap", 1, 0);
        if (out_d.size() == 1) chk("wrap_zero", out_d[0], 64'd0);

        // randomized sizes, data, stalls and response delays
        fixed_mode = 1'b0;
        stall_max  = 2;
        delay_max  = 3;
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(0, 5));
            m = int'($urandom_range(0, 4));
            for (int i = 0; i < 16; i++) begin
                X[i] = rnd64();
                U[i] = rnd64();
                for (int j = 0; j < 16; j++) begin
                    A[i][j] = rnd64();
                    B[i][j] = rnd64();
                end
            end
            run_case("rand", n, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
